// File: rtl/spi_adc_pkg.sv
// Shared definitions for the ADC SPI responder.
//   state_t     : responder frame state
//   CMD_BITS    : command bits after the start bit (sgl, d2, d1, d0)
//   SYNC_STAGES : synchroniser depth for the asynchronous SPI pins
//   chan_ok()   : channel-range check against the configured channel count
package spi_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    NULL,
    DATA,
    TAIL
  } state_t;

  localparam int unsigned CMD_BITS    = 4;
  localparam int unsigned SYNC_STAGES = 2;

  function automatic logic chan_ok(input logic [2:0] chan, input int unsigned num_channels);
    return {29'd0, chan} < num_channels;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus registered edge detector for one asynchronous bit.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input pin
//   q        : synchronised level, time-aligned with rise/fall
//   rise     : one-cycle pulse on a 0->1 transition
//   fall     : one-cycle pulse on a 1->0 transition
// Latency pin -> rise/fall is STAGES + 1 clk cycles.
module spi_sync_edge
  import spi_adc_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES,
  parameter logic        INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // prev doubles as the level output so q lines up with the edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign q = prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating an ADC: decodes a start bit plus 4-bit command
// (sgl, d2, d1, d0), requests a sample, returns a null bit and then the
// sample MSB-first on MISO (SPI mode 0, oversampled in the clk domain).
//   clk, rst        : system clock, synchronous active-high reset
//   sclk, cs, mosi  : asynchronous SPI inputs (cs active low)
//   miso, miso_oe   : serial data and its drive enable
//   req_valid       : one-cycle sample request; req_chan/req_sgl held
//   rsp_valid/data  : sample return, first valid inside the window wins
//   frame_done      : pulse on a normal frame end
//   underrun        : pulse when no sample arrived before the first data bit
//   cmd_err         : pulse when the command selects a nonexistent channel
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH    = 8,
  parameter int unsigned NUM_CHANNELS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 req_valid,
  output logic [2:0]           req_chan,
  output logic                 req_sgl,
  input  logic                 rsp_valid,
  input  logic [ADC_WIDTH-1:0] rsp_data,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 cmd_err
);

  localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(ADC_WIDTH - 1);

  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs idles high; starting the synchroniser high avoids a false edge out of reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t               state;
  logic [3:0]           bit_cnt;
  logic [3:0]           cmd_sr;
  logic [ADC_WIDTH-1:0] data_sr;
  logic                 rsp_got;
  logic                 chan_err;

  logic                 ev_rise, ev_fall;
  logic [3:0]           cmd_next;
  logic                 cmd_chan_ok;
  logic [ADC_WIDTH-1:0] first_word;

  always_comb begin
    ev_rise     = sclk_rise & ~cs_q;
    ev_fall     = sclk_fall & ~cs_q;
    cmd_next    = {cmd_sr[2:0], mosi_q};
    cmd_chan_ok = chan_ok(cmd_next[2:0], NUM_CHANNELS);
    // A response arriving in the very cycle of the DATA-entry FALL still counts.
    first_word  = '0;
    if (!chan_err) begin
      if (rsp_got)        first_word = data_sr;
      else if (rsp_valid) first_word = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      data_sr    <= '0;
      rsp_got    <= 1'b0;
      chan_err   <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      req_valid  <= 1'b0;
      req_chan   <= '0;
      req_sgl    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      req_valid  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      cmd_err    <= 1'b0;

      if (cs_rise) begin
        state      <= IDLE;
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
        rsp_got    <= 1'b0;
        frame_done <= (state == TAIL);
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              state    <= START;
              miso_oe  <= 1'b1;
              rsp_got  <= 1'b0;
              chan_err <= 1'b0;
            end
          end

          START: begin
            if (ev_rise && mosi_q) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end

          CMD: begin
            if (ev_rise) begin
              cmd_sr  <= cmd_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == CMD_LAST) begin
                state     <= NULL;
                bit_cnt   <= '0;
                req_valid <= 1'b1;
                req_chan  <= cmd_next[2:0];
                req_sgl   <= cmd_next[3];
                chan_err  <= ~cmd_chan_ok;
                cmd_err   <= ~cmd_chan_ok;
              end
            end
          end

          NULL: begin
            if (rsp_valid && !rsp_got) begin
              rsp_got <= 1'b1;
              data_sr <= rsp_data;
            end
            if (ev_fall) begin
              if (bit_cnt == 4'd0) begin
                miso    <= 1'b0;
                bit_cnt <= 4'd1;
              end else begin
                state    <= (ADC_WIDTH == 1) ? TAIL : DATA;
                miso     <= first_word[ADC_WIDTH-1];
                data_sr  <= first_word << 1;
                bit_cnt  <= 4'd1;
                underrun <= ~rsp_got & ~rsp_valid;
              end
            end
          end

          DATA: begin
            if (ev_fall) begin
              miso    <= data_sr[ADC_WIDTH-1];
              data_sr <= data_sr << 1;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == DATA_LAST) state <= TAIL;
            end
          end

          TAIL: begin
            if (ev_fall) miso <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
module tb_spi_adc_responder;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       req_valid;
  logic [2:0] req_chan;
  logic       req_sgl;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       frame_done;
  logic       underrun;
  logic       cmd_err;

  spi_adc_responder #(.ADC_WIDTH(8), .NUM_CHANNELS(1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .req_valid(req_valid), .req_chan(req_chan), .req_sgl(req_sgl),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .frame_done(frame_done), .underrun(underrun), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nchk = 0;
  int unsigned nfail = 0;

  int unsigned n_req = 0, n_done = 0, n_under = 0, n_err = 0;
  time         t_req = 0, t_under = 0;
  time         t_rise5 = 0, t_fall_entry = 0;
  logic        samp [0:31];
  logic        oe_mid;

  int unsigned rsp_mode = 0;     // 0: answer 2 cycles after req_valid, 1: withhold
  logic [7:0]  rsp_next = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (req_valid)  begin n_req++; t_req = $time; end
    if (frame_done) n_done++;
    if (underrun)   begin n_under++; t_under = $time; end
    if (cmd_err)    n_err++;
  end

  // Sample source.
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (req_valid && rsp_mode == 0) begin
        repeat (2) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = rsp_next;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
      end
    end
  end

  // SCLK = clk/4. samp[i] is the MISO bit launched by the falling edge of
  // SCLK cycle i, captured just before the following falling edge.
  task automatic spi_frame(input int unsigned lead, input logic [4:0] cmd, input int unsigned ncyc);
    int unsigned k;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int unsigned i = 0; i < ncyc; i++) begin
      if (i < lead) mosi = 1'b0;
      else begin
        k = i - lead;
        mosi = (k < 5) ? cmd[4-k] : 1'b0;
      end
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      if (i == lead + 4) t_rise5 = $time;
      repeat (2) @(negedge clk);
      if (i > 0) samp[i-1] = miso;
      if (i == 2) oe_mid = miso_oe;
      sclk = 1'b0;
      if (i == lead + 5) t_fall_entry = $time;
    end
    repeat (4) @(negedge clk);
    samp[ncyc-1] = miso;
  endtask

  task automatic end_frame();
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [7:0] data_bits(input int unsigned base);
    logic [7:0] v;
    for (int unsigned b = 0; b < 8; b++) v[7-b] = samp[base+b];
    return v;
  endfunction

  int unsigned done0, req0, under0, err0;
  logic [31:0] allbits;

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_chan", 32'(req_chan), 32'd0);
    check("rst_pulses", {29'd0, frame_done, underrun, cmd_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Channel 0 single-ended, sample 0xA5.
    done0 = n_done; req0 = n_req; under0 = n_under;
    rsp_mode = 0; rsp_next = 8'hA5;
    spi_frame(0, 5'b11000, 14);
    end_frame();
    check("s1_req_count", n_req - req0, 1);
    check("s1_req_chan", 32'(req_chan), 32'd0);
    check("s1_req_sgl", 32'(req_sgl), 32'd1);
    check("s1_req_latency", 32'(t_req - t_rise5), 32'd40);
    check("s1_oe_mid", 32'(oe_mid), 32'd1);
    check("s1_null_bit", 32'(samp[4]), 32'd0);
    check("s1_data", 32'(data_bits(5)), 32'hA5);
    check("s1_tail_bit", 32'(samp[13]), 32'd0);
    check("s1_done", n_done - done0, 1);
    check("s1_no_underrun", n_under - under0, 0);
    check("s1_oe_after", 32'(miso_oe), 32'd0);

    // Three leading zeros before the start bit.
    done0 = n_done;
    rsp_next = 8'hA5;
    spi_frame(3, 5'b11000, 17);
    end_frame();
    check("s2_req_chan", 32'(req_chan), 32'd0);
    check("s2_req_sgl", 32'(req_sgl), 32'd1);
    check("s2_data", 32'(data_bits(8)), 32'hA5);
    check("s2_done", n_done - done0, 1);

    // Response withheld.
    done0 = n_done; under0 = n_under;
    rsp_mode = 1;
    spi_frame(0, 5'b11000, 14);
    end_frame();
    rsp_mode = 0;
    check("s3_underrun", n_under - under0, 1);
    check("s3_underrun_time", 32'(t_under - t_fall_entry), 32'd40);
    check("s3_data_zero", 32'(data_bits(5)), 32'h00);
    check("s3_done", n_done - done0, 1);

    // Channel 3 selected with one channel configured.
    err0 = n_err;
    rsp_next = 8'hFF;
    spi_frame(0, 5'b11011, 14);
    end_frame();
    allbits = '0;
    for (int unsigned b = 0; b < 14; b++) allbits[b] = samp[b];
    check("s4_cmd_err", n_err - err0, 1);
    check("s4_req_chan", 32'(req_chan), 32'd3);
    check("s4_miso_zero", allbits, 32'd0);

    // cs raised after three data bits.
    done0 = n_done;
    rsp_next = 8'h99;
    spi_frame(0, 5'b11000, 8);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_oe_3cyc", 32'(miso_oe), 32'd1);
    @(negedge clk);
    check("s5_oe_4cyc", 32'(miso_oe), 32'd0);
    repeat (8) @(negedge clk);
    check("s5_no_done", n_done - done0, 0);
    rsp_next = 8'h3C;
    spi_frame(0, 5'b11000, 14);
    end_frame();
    check("s5_next_data", 32'(data_bits(5)), 32'h3C);
    check("s5_next_done", n_done - done0, 1);

    // Reset pulse mid-DATA.
    rsp_next = 8'h81;
    spi_frame(0, 5'b11000, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_miso_oe", 32'(miso_oe), 32'd0);
    check("s6_miso", 32'(miso), 32'd0);
    check("s6_req_sgl", 32'(req_sgl), 32'd0);
    check("s6_req_chan", 32'(req_chan), 32'd0);
    check("s6_pulses", {28'd0, req_valid, frame_done, underrun, cmd_err}, 32'd0);
    end_frame();
    done0 = n_done;
    rsp_next = 8'h5A;
    spi_frame(0, 5'b11000, 14);
    end_frame();
    check("s6_req_sgl_after", 32'(req_sgl), 32'd1);
    check("s6_data", 32'(data_bits(5)), 32'h5A);
    check("s6_done", n_done - done0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
